ecc_param_rom: RTL and testbench

Parametrised, reset-initialised constant table for the ECC datapath. It replaces the fixed 64×16 register ROM with configurable width and depth. The single-word read port keeps the same strobe behaviour. It adds a burst-streaming read channel with valid/ready handshake, and an optional lockable runtime write port. Curve constants, key material and test vectors are held here and streamed into the ECC arithmetic core.

---
 rtl/ecc_param_rom.sv | 170 +++++++++++++++++
 tb/tb_ecc_param_rom.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_param_rom.sv
// ecc_param_rom: reset-initialised constant table for the ECC datapath.
// Single-word strobe read port (CEN/A/Q) plus a burst-streaming read
// channel with valid/ready handshake.
// Optional feature macro: ECC_PROM_WRITE_EN adds a lockable runtime write
// port (WEN/WA/WD/lock_set/wr_err). Without it the table is constant INIT.
module ecc_param_rom #(
    parameter int unsigned            DW    = 16,
    parameter int unsigned            DEPTH = 64,
    parameter logic [DW*DEPTH-1:0]    INIT  = '1
) (
    input  logic                     CLK,
    input  logic                     rst_n,
    input  logic                     CEN,
    input  logic [$clog2(DEPTH)-1:0] A,
    output logic [DW-1:0]            Q,
    input  logic                     bst_start,
    input  logic [$clog2(DEPTH)-1:0] bst_addr,
    input  logic [$clog2(DEPTH)-1:0] bst_len,
    output logic [DW-1:0]            bst_data,
    output logic                     bst_valid,
    input  logic                     bst_ready,
    output logic                     bst_last,
    output logic                     bst_busy
`ifdef ECC_PROM_WRITE_EN
    ,
    input  logic                     WEN,
    input  logic [$clog2(DEPTH)-1:0] WA,
    input  logic [DW-1:0]            WD,
    input  logic                     lock_set,
    output logic                     wr_err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    // Read view of the table; every read path uses this (pre-write) value,
    // so same-cycle read/write collisions return the old entry.
    logic [DW-1:0] w_mem [DEPTH];

`ifdef ECC_PROM_WRITE_EN
    logic [DW-1:0] r_mem [DEPTH];
    logic          r_lock;
    logic          r_wr_err;

    // Table storage: reload INIT on reset, commit unlocked writes.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= INIT[i*DW +: DW];
            end
        end else if (!WEN && !r_lock) begin
            r_mem[WA] <= WD;
        end
    end

    // Sticky lock (cleared only by reset) and one-cycle locked-write error.
    // Lock uses its pre-edge value, so a write alongside lock_set commits.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_lock   <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_lock   <= r_lock | lock_set;
            r_wr_err <= !WEN && r_lock;
        end
    end

    // Expose stored contents as the read view.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_mem[i] = r_mem[i];
        end
    end

    assign wr_err = r_wr_err;
`else
    // Constant table: entries are the INIT slices.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_mem[i] = INIT[i*DW +: DW];
        end
    end
`endif

    logic [DW-1:0] r_q;

    // Single-read port: registered, holds while CEN is high.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (!CEN) begin
            r_q <= w_mem[A];
        end
    end

    assign Q = r_q;

    // Burst channel state
    state_t        r_state, w_state_nx;
    logic [AW-1:0] r_ptr, w_ptr_nx;
    logic [AW-1:0] r_cnt, w_cnt_nx;
    logic [DW-1:0] r_bdata, w_bdata_nx;
    logic          r_last, w_last_nx;
    logic [AW-1:0] w_ptr_inc;

    assign w_ptr_inc = r_ptr + AW'(1);

    // Burst state registers.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_bdata <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_cnt   <= w_cnt_nx;
            r_bdata <= w_bdata_nx;
            r_last  <= w_last_nx;
        end
    end

    // Burst next-state: start when idle, advance on accepted beats,
    // hold everything (including fetched data) while stalled.
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_cnt_nx   = r_cnt;
        w_bdata_nx = r_bdata;
        w_last_nx  = r_last;
        case (r_state)
            S_IDLE: begin
                if (bst_start) begin
                    w_ptr_nx   = bst_addr;
                    w_cnt_nx   = bst_len;
                    w_bdata_nx = w_mem[bst_addr];
                    w_last_nx  = (bst_len == '0);
                    w_state_nx = S_STREAM;
                end
            end
            S_STREAM: begin
                if (bst_ready) begin
                    if (r_cnt != '0) begin
                        w_ptr_nx   = w_ptr_inc;
                        w_bdata_nx = w_mem[w_ptr_inc];
                        w_cnt_nx   = r_cnt - AW'(1);
                        w_last_nx  = (r_cnt == AW'(1));
                    end else begin
                        w_last_nx  = 1'b0;
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign bst_data  = r_bdata;
    assign bst_last  = r_last;
    assign bst_valid = (r_state == S_STREAM);
    assign bst_busy  = (r_state == S_STREAM);

endmodule

// File: tb/tb_ecc_param_rom.sv
// Directed self-checking bench for ecc_param_rom (DW=16, DEPTH=64,
// entry i = 16'hA500 + i). Write/lock scenarios run when
// ECC_PROM_WRITE_EN is defined.
module tb_ecc_param_rom;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 6;

    function automatic logic [DW*DEPTH-1:0] mk_init();
        logic [DW*DEPTH-1:0] v;
        v = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v[i*DW +: DW] = 16'hA500 + 16'(i);
        end
        return v;
    endfunction

    localparam logic [DW*DEPTH-1:0] TB_INIT = mk_init();

    logic          CLK = 1'b0;
    logic          rst_n;
    logic          CEN;
    logic [AW-1:0] A;
    logic [DW-1:0] Q;
    logic          bst_start;
    logic [AW-1:0] bst_addr;
    logic [AW-1:0] bst_len;
    logic [DW-1:0] bst_data;
    logic          bst_valid;
    logic          bst_ready;
    logic          bst_last;
    logic          bst_busy;
`ifdef ECC_PROM_WRITE_EN
    logic          WEN;
    logic [AW-1:0] WA;
    logic [DW-1:0] WD;
    logic          lock_set;
    logic          wr_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    ecc_param_rom #(
        .DW   (DW),
        .DEPTH(DEPTH),
        .INIT (TB_INIT)
    ) dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .CEN      (CEN),
        .A        (A),
        .Q        (Q),
        .bst_start(bst_start),
        .bst_addr (bst_addr),
        .bst_len  (bst_len),
        .bst_data (bst_data),
        .bst_valid(bst_valid),
        .bst_ready(bst_ready),
        .bst_last (bst_last),
        .bst_busy (bst_busy)
`ifdef ECC_PROM_WRITE_EN
        ,
        .WEN      (WEN),
        .WA       (WA),
        .WD       (WD),
        .lock_set (lock_set),
        .wr_err   (wr_err)
`endif
    );

    task automatic test_reset();
        rst_n = 1'b0; CEN = 1'b1; A = '0;
        bst_start = 1'b0; bst_addr = '0; bst_len = '0; bst_ready = 1'b0;
`ifdef ECC_PROM_WRITE_EN
        WEN = 1'b1; WA = '0; WD = '0; lock_set = 1'b0;
`endif
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({Q, bst_data} !== 32'h0) begin
            n_bad++; $display("FAIL reset_data: got Q=%h bst_data=%h, want 0/0", Q, bst_data);
        end
        n_cmp++;
        if ({bst_valid, bst_last, bst_busy} !== 3'b000) begin
            n_bad++; $display("FAIL reset_ctrl: got v/l/b=%b, want 000", {bst_valid, bst_last, bst_busy});
        end
`ifdef ECC_PROM_WRITE_EN
        n_cmp++;
        if (wr_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_wr_err: got %b, want 0", wr_err);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        @(negedge CLK);
        CEN = 1'b0; A = 6'd5;
        @(negedge CLK);
        n_cmp++;
        if (Q !== 16'hA505) begin
            n_bad++; $display("FAIL single_read: got %h, want A505", Q);
        end
        CEN = 1'b1; A = 6'd9;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            n_cmp++;
            if (Q !== 16'hA505) begin
                n_bad++; $display("FAIL single_hold%0d: got %h, want A505", c, Q);
            end
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (Q !== 16'h0) begin
            n_bad++; $display("FAIL q_async_reset: got %h, want 0000", Q);
        end
        @(negedge CLK);
        rst_n = 1'b1;
    endtask

    task automatic test_burst_wrap();
        logic [DW-1:0] exp [4];
        exp[0] = 16'hA53E; exp[1] = 16'hA53F; exp[2] = 16'hA500; exp[3] = 16'hA501;
        @(negedge CLK);
        bst_start = 1'b1; bst_addr = 6'd62; bst_len = 6'd3; bst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            bst_start = 1'b0;
            n_cmp++;
            if ({bst_valid, bst_busy, bst_last, bst_data} !== {1'b1, 1'b1, (k == 3), exp[k]}) begin
                n_bad++;
                $display("FAIL burst_beat%0d: got v/b/l=%b%b%b data=%h, want 11%b data=%h",
                         k, bst_valid, bst_busy, bst_last, bst_data, (k == 3), exp[k]);
            end
        end
        @(negedge CLK);
        n_cmp++;
        if ({bst_valid, bst_busy, bst_last} !== 3'b000) begin
            n_bad++; $display("FAIL burst_end: got v/b/l=%b%b%b, want 000", bst_valid, bst_busy, bst_last);
        end
    endtask

    task automatic test_burst_stall();
        logic [DW-1:0] exp [4];
        logic          pat [6];
        int            beat;
        exp[0] = 16'hA53E; exp[1] = 16'hA53F; exp[2] = 16'hA500; exp[3] = 16'hA501;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0; pat[4] = 1'b1; pat[5] = 1'b1;
        beat = 0;
        @(negedge CLK);
        bst_start = 1'b1; bst_addr = 6'd62; bst_len = 6'd3; bst_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            n_cmp++;
            if ({bst_valid, bst_last, bst_data} !== {1'b1, (beat == 3), exp[beat]}) begin
                n_bad++;
                $display("FAIL stall_c%0d: got v/l=%b%b data=%h, want 1%b data=%h",
                         c, bst_valid, bst_last, bst_data, (beat == 3), exp[beat]);
            end
            bst_ready = pat[c];
            // Competing start request while busy must be ignored.
            bst_start = 1'b1; bst_addr = 6'd0; bst_len = 6'd0;
            if (pat[c]) beat++;
        end
        @(negedge CLK);
        bst_start = 1'b0; bst_ready = 1'b0;
        n_cmp++;
        if ({bst_valid, bst_busy, bst_last} !== 3'b000 || beat != 4) begin
            n_bad++;
            $display("FAIL stall_end: got v/b/l=%b%b%b beats=%0d, want 000 beats=4",
                     bst_valid, bst_busy, bst_last, beat);
        end
        @(negedge CLK);
        n_cmp++;
        if (bst_busy !== 1'b0) begin
            n_bad++; $display("FAIL stall_no_restart: got busy=%b, want 0", bst_busy);
        end
    endtask

`ifdef ECC_PROM_WRITE_EN
    task automatic test_write_collision();
        @(negedge CLK);
        WEN = 1'b0; WA = 6'd7; WD = 16'h1234; CEN = 1'b0; A = 6'd7;
        @(negedge CLK);
        WEN = 1'b1;
        n_cmp++;
        if (Q !== 16'hA507) begin
            n_bad++; $display("FAIL wr_collision_old: got %h, want A507", Q);
        end
        @(negedge CLK);
        n_cmp++;
        if (Q !== 16'h1234) begin
            n_bad++; $display("FAIL wr_new_value: got %h, want 1234", Q);
        end
        CEN = 1'b1;
    endtask

    task automatic test_lock();
        @(negedge CLK);
        lock_set = 1'b1; WEN = 1'b0; WA = 6'd8; WD = 16'h5555;
        @(negedge CLK);
        lock_set = 1'b0; WEN = 1'b0; WA = 6'd7; WD = 16'hFFFF;
        @(negedge CLK);
        WEN = 1'b1; CEN = 1'b0; A = 6'd7;
        n_cmp++;
        if (wr_err !== 1'b1) begin
            n_bad++; $display("FAIL lock_wr_err: got %b, want 1", wr_err);
        end
        @(negedge CLK);
        A = 6'd8;
        n_cmp++;
        if ({wr_err, Q} !== {1'b0, 16'h1234}) begin
            n_bad++; $display("FAIL lock_blocked: got err=%b Q=%h, want err=0 Q=1234", wr_err, Q);
        end
        @(negedge CLK);
        n_cmp++;
        if (Q !== 16'h5555) begin
            n_bad++; $display("FAIL lock_same_cycle_write: got %h, want 5555", Q);
        end
        rst_n = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1; A = 6'd7;
        @(negedge CLK);
        n_cmp++;
        if (Q !== 16'hA507) begin
            n_bad++; $display("FAIL reset_restores: got %h, want A507", Q);
        end
        WEN = 1'b0; WD = 16'hBEEF; WA = 6'd7;
        @(negedge CLK);
        WEN = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if ({wr_err, Q} !== {1'b0, 16'hBEEF}) begin
            n_bad++; $display("FAIL lock_cleared: got err=%b Q=%h, want err=0 Q=BEEF", wr_err, Q);
        end
        CEN = 1'b1;
    endtask
`endif

    task automatic test_reset_midburst();
        @(negedge CLK);
        bst_start = 1'b1; bst_addr = 6'd0; bst_len = 6'd9; bst_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            bst_start = 1'b0;
            n_cmp++;
            if ({bst_valid, bst_data} !== {1'b1, 16'hA500 + 16'(k)}) begin
                n_bad++; $display("FAIL mid_beat%0d: got v=%b data=%h, want 1 %h",
                                  k, bst_valid, bst_data, 16'hA500 + 16'(k));
            end
        end
        @(negedge CLK);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bst_valid, bst_busy, bst_last} !== 3'b000) begin
            n_bad++; $display("FAIL mid_reset: got v/b/l=%b%b%b, want 000", bst_valid, bst_busy, bst_last);
        end
        @(negedge CLK);
        rst_n = 1'b1;
        bst_start = 1'b1; bst_addr = 6'd0; bst_len = 6'd0;
        @(negedge CLK);
        bst_start = 1'b0;
        n_cmp++;
        if ({bst_valid, bst_last, bst_data} !== {1'b1, 1'b1, 16'hA500}) begin
            n_bad++; $display("FAIL single_beat: got v/l=%b%b data=%h, want 11 A500", bst_valid, bst_last, bst_data);
        end
        @(negedge CLK);
        n_cmp++;
        if ({bst_valid, bst_busy, bst_last} !== 3'b000) begin
            n_bad++; $display("FAIL single_beat_end: got v/b/l=%b%b%b, want 000", bst_valid, bst_busy, bst_last);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_burst_wrap();
        test_burst_stall();
`ifdef ECC_PROM_WRITE_EN
        test_write_collision();
        test_lock();
`endif
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
